// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sums a frame of unsigned products coming from an upstream multiplier and
// presents the frame total, beat count and an overflow flag on a registered
// valid/ready result port. A frame is a run of accepted beats ending with a
// beat marked in_last.
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   product beat valid
//   in_ready   block can accept a beat this cycle (low while a result waits)
//   in_r       unsigned product, 2*N bits
//   in_last    beat closes the frame
//   out_valid  frame result valid (registered)
//   out_ready  consumer takes the result
//   out_sum    frame sum, W = 2*N+G bits
//   out_count  number of beats in the frame (saturates at 65535)
//   out_ovf    the running sum carried out of bit W-1 during the frame
//
// Build option
//   PRODUCT_ACCUMULATOR_SATURATE_EN : when defined the accumulator clamps at
//   2^W-1 on carry-out instead of wrapping. out_ovf is the same either way.
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int N = 16,
  parameter int G = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N-1:0]     in_r,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N+G-1:0]   out_sum,
  output logic [15:0]        out_count,
  output logic               out_ovf
);

  localparam int W = 2*N + G;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]   state_r;
  logic [1:0]   state_nxt_s;
  logic [W-1:0] acc_r;
  logic [15:0]  count_r;
  logic         ovf_r;

  logic         accept_s;
  logic [W:0]   sum_ext_s;
  logic [W-1:0] acc_nxt_s;
  logic [15:0]  count_nxt_s;
  logic         ovf_nxt_s;

  // in_ready comes from the state register alone, so it never depends on in_valid
  assign in_ready = (state_r == HOLD) ? 1'b0 : 1'b1;
  assign accept_s = in_valid & in_ready;

  // Next accumulator/count/overflow for an accepted beat; outside ACC a beat
  // starts a fresh frame so nothing from the previous frame leaks in
  always_comb begin
    sum_ext_s   = {(W+1){1'b0}};
    count_nxt_s = 16'd1;
    ovf_nxt_s   = 1'b0;
    if (state_r == ACC) begin
      sum_ext_s   = {1'b0, acc_r} + {{(G+1){1'b0}}, in_r};
      count_nxt_s = (count_r == 16'hFFFF) ? count_r : (count_r + 16'd1);
      ovf_nxt_s   = ovf_r | sum_ext_s[W];
    end else begin
      sum_ext_s   = {{(G+1){1'b0}}, in_r};
      count_nxt_s = 16'd1;
      ovf_nxt_s   = 1'b0;
    end
  end

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  // Clamp on carry-out; once at all-ones any further beat carries again (or
  // adds zero), so the value stays clamped for the rest of the frame
  always_comb begin
    acc_nxt_s = {W{1'b0}};
    if (sum_ext_s[W]) begin
      acc_nxt_s = {W{1'b1}};
    end else begin
      acc_nxt_s = sum_ext_s[W-1:0];
    end
  end
`else
  // Wrap modulo 2^W
  always_comb begin
    acc_nxt_s = sum_ext_s[W-1:0];
  end
`endif

  // Frame state machine transitions
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && in_last) begin
          state_nxt_s = HOLD;
        end else if (accept_s) begin
          state_nxt_s = ACC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (accept_s && in_last) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and running accumulator; idle cycles leave everything untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= {W{1'b0}};
      count_r <= 16'd0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        acc_r   <= acc_nxt_s;
        count_r <= count_nxt_s;
        ovf_r   <= ovf_nxt_s;
      end
    end
  end

  // Result registers capture the total including the last beat, so out_valid
  // rises the cycle after that beat and holds until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= {W{1'b0}};
      out_count <= 16'd0;
      out_ovf   <= 1'b0;
    end else if (accept_s && in_last) begin
      out_valid <= 1'b1;
      out_sum   <= acc_nxt_s;
      out_count <= count_nxt_s;
      out_ovf   <= ovf_nxt_s;
    end else if ((state_r == HOLD) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
